// File: rtl/fp_mul_param.sv
// fp_mul_param: multi-cycle IEEE-754 binary floating-point multiplier with
// configurable exponent/fraction widths, four rounding modes, subnormal
// support and IEEE exception flags.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; aborts any operation in flight
//   din1/din2 operands {sign, exponent, fraction}, sampled on accept
//   rmode     00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   din_rdy   operands valid; only looked at while idle and not busy
//   busy      high from the cycle after accept until dout_rdy pulses
//   dout      result, held until the next operation completes
//   dout_rdy  one-cycle pulse marking a fresh result
//   flags     {invalid, overflow, underflow, inexact}, held with dout
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] din1,
  input  logic [EXP_W+MAN_W:0] din2,
  input  logic [1:0]           rmode,
  input  logic                 din_rdy,
  output logic                 busy,
  output logic [EXP_W+MAN_W:0] dout,
  output logic                 dout_rdy,
  output logic [3:0]           flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;        // significand incl. hidden bit
  localparam int PW = 2 * SW;           // full product width
  localparam int XW = EXP_W + 3;        // signed working exponent, never wraps
  localparam int B  = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [XW-1:0] E_MIN = XW'(1 - B);
  localparam logic signed [XW-1:0] E_MAX = XW'(B);
  localparam logic signed [XW-1:0] E_COL = XW'(1 - B - MAN_W - 2);
  localparam logic signed [XW-1:0] E_ONE = XW'(1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] MAG_INF = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] MAG_MAX = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_MUL, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [1:0][W-1:0]  op_reg;
  logic [1:0]         rm_reg;
  logic               sign_reg;
  logic [1:0][XW-1:0] ue_reg;
  logic [1:0][SW-1:0] us_reg;
  logic [1:0]         zero_reg, inf_reg, nan_reg;
  logic [PW-1:0]      prod_reg;
  logic signed [XW-1:0] exp_reg;
  logic               sticky_reg;
  logic [SW-1:0]      sig_reg;
  logic               inexact_reg;
  logic [W-1:0]       res_reg;
  logic [3:0]         flg_reg;

  logic accept;
  assign accept = (state_reg == S_IDLE) && din_rdy && !busy;

  // ---------------- field unpacking, one copy per operand ----------------
  logic [1:0][EXP_W-1:0] u_fexp;
  logic [1:0][MAN_W-1:0] u_frac;
  logic [1:0][XW-1:0]    u_exp;
  logic [1:0][SW-1:0]    u_sig;
  logic [1:0]            u_zero, u_inf, u_nan;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign u_fexp[gi] = op_reg[gi][W-2:MAN_W];
      assign u_frac[gi] = op_reg[gi][MAN_W-1:0];
      // Subnormals share the minimum exponent; only the hidden bit differs.
      assign u_exp[gi]  = (u_fexp[gi] == '0) ? E_MIN
                        : ({3'b000, u_fexp[gi]} - XW'(B));
      assign u_sig[gi]  = {|u_fexp[gi], u_frac[gi]};
      assign u_zero[gi] = ~|u_fexp[gi] & ~|u_frac[gi];
      assign u_inf[gi]  = &u_fexp[gi] & ~|u_frac[gi];
      assign u_nan[gi]  = &u_fexp[gi] & |u_frac[gi];
    end
  endgenerate

  // ---------------- special-operand decision ----------------
  logic sp_nan, sp_any;
  logic [W-1:0] sp_res;
  always_comb begin
    sp_nan = |nan_reg | (inf_reg[0] & zero_reg[1]) | (zero_reg[0] & inf_reg[1]);
    sp_any = sp_nan | (|inf_reg) | (|zero_reg);
    if (sp_nan)        sp_res = QNAN;
    else if (|inf_reg) sp_res = {sign_reg, MAG_INF};
    else               sp_res = {sign_reg, {(W-1){1'b0}}};
  end

  // ---------------- normalisation step ----------------
  // The product MSB carries the hidden bit at weight 2^exp. Each NORM cycle
  // performs one step; the exit test is made on the stepped value so the
  // common single-shift case leaves NORM in one cycle.
  logic [PW-1:0]        n_prod;
  logic signed [XW-1:0] n_exp;
  logic                 n_sticky, n_more;
  always_comb begin
    n_prod   = prod_reg;
    n_exp    = exp_reg;
    n_sticky = sticky_reg;
    if (exp_reg < E_COL) begin
      // Far below the subnormal range: only stickiness survives.
      n_prod   = '0;
      n_exp    = E_MIN;
      n_sticky = sticky_reg | (|prod_reg);
    end else if (!prod_reg[PW-1] && (exp_reg > E_MIN)) begin
      n_prod = prod_reg << 1;
      n_exp  = exp_reg - E_ONE;
    end else if (exp_reg < E_MIN) begin
      n_prod   = prod_reg >> 1;
      n_exp    = exp_reg + E_ONE;
      n_sticky = sticky_reg | prod_reg[0];
    end
    n_more = (n_exp < E_COL) || (!n_prod[PW-1] && (n_exp > E_MIN)) || (n_exp < E_MIN);
  end

  // ---------------- rounding ----------------
  logic [SW-1:0]        r_kept, r_sig;
  logic                 r_g, r_r, r_s, r_inc;
  logic [SW:0]          r_sum;
  logic signed [XW-1:0] r_exp;
  always_comb begin
    r_kept = prod_reg[PW-1 -: SW];
    r_g    = prod_reg[MAN_W];
    r_r    = prod_reg[MAN_W-1];
    r_s    = sticky_reg | (|prod_reg[MAN_W-2:0]);
    case (rm_reg)
      RM_RNE:  r_inc = r_g & (r_r | r_s | r_kept[0]);
      RM_RTZ:  r_inc = 1'b0;
      RM_RUP:  r_inc = (r_g | r_r | r_s) & ~sign_reg;
      default: r_inc = (r_g | r_r | r_s) & sign_reg;
    endcase
    r_sum = {1'b0, r_kept} + {{SW{1'b0}}, r_inc};
    // A subnormal rounding into the hidden bit needs no special case: the
    // exponent is already E_MIN, so it packs as the minimum normal.
    if (r_sum[SW]) begin
      r_sig = r_sum[SW:1];
      r_exp = exp_reg + E_ONE;
    end else begin
      r_sig = r_sum[SW-1:0];
      r_exp = exp_reg;
    end
  end

  // ---------------- packing / overflow ----------------
  logic             p_tiny;
  logic [EXP_W-1:0] p_bexp;
  logic [W-1:0]     p_res;
  logic [3:0]       p_flags;
  always_comb begin
    p_tiny  = ~sig_reg[MAN_W];
    p_bexp  = EXP_W'(exp_reg + E_MAX);
    p_res   = {sign_reg, (p_tiny ? {EXP_W{1'b0}} : p_bexp), sig_reg[MAN_W-1:0]};
    p_flags = {2'b00, p_tiny & inexact_reg, inexact_reg};
    if (exp_reg > E_MAX) begin
      p_flags = 4'b0101;
      case (rm_reg)
        RM_RNE:  p_res = {sign_reg, MAG_INF};
        RM_RTZ:  p_res = {sign_reg, MAG_MAX};
        RM_RUP:  p_res = sign_reg ? {1'b1, MAG_MAX} : {1'b0, MAG_INF};
        default: p_res = sign_reg ? {1'b1, MAG_INF} : {1'b0, MAG_MAX};
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (accept) state_next = S_UNPACK;
      S_UNPACK:  state_next = S_SPECIAL;
      S_SPECIAL: state_next = sp_any ? S_DONE : S_MUL;
      S_MUL:     state_next = S_NORM;
      S_NORM:    state_next = n_more ? S_NORM : S_ROUND;
      S_ROUND:   state_next = S_PACK;
      S_PACK:    state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= '0;
      rm_reg      <= '0;
      sign_reg    <= 1'b0;
      ue_reg      <= '0;
      us_reg      <= '0;
      zero_reg    <= '0;
      inf_reg     <= '0;
      nan_reg     <= '0;
      prod_reg    <= '0;
      exp_reg     <= '0;
      sticky_reg  <= 1'b0;
      sig_reg     <= '0;
      inexact_reg <= 1'b0;
      res_reg     <= '0;
      flg_reg     <= '0;
      dout        <= '0;
      flags       <= '0;
      dout_rdy    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dout_rdy <= 1'b0;
      case (state_reg)
        S_IDLE: if (accept) begin
          op_reg[0] <= din1;
          op_reg[1] <= din2;
          rm_reg    <= rmode;
          busy      <= 1'b1;
        end
        S_UNPACK: begin
          ue_reg   <= u_exp;
          us_reg   <= u_sig;
          zero_reg <= u_zero;
          inf_reg  <= u_inf;
          nan_reg  <= u_nan;
          sign_reg <= op_reg[0][W-1] ^ op_reg[1][W-1];
        end
        S_SPECIAL: if (sp_any) begin
          res_reg <= sp_res;
          flg_reg <= {sp_nan, 3'b000};
        end
        S_MUL: begin
          prod_reg   <= PW'(us_reg[0]) * PW'(us_reg[1]);
          exp_reg    <= $signed(ue_reg[0]) + $signed(ue_reg[1]) + E_ONE;
          sticky_reg <= 1'b0;
        end
        S_NORM: begin
          prod_reg   <= n_prod;
          exp_reg    <= n_exp;
          sticky_reg <= n_sticky;
        end
        S_ROUND: begin
          sig_reg     <= r_sig;
          exp_reg     <= r_exp;
          inexact_reg <= r_g | r_r | r_s;
        end
        S_PACK: begin
          res_reg <= p_res;
          flg_reg <= p_flags;
        end
        S_DONE: begin
          dout     <= res_reg;
          flags    <= flg_reg;
          dout_rdy <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fp_mul_param.md
Name: fp_mul_param

Overview:
- Parametrised IEEE-754 binary floating-point multiplier; successor to the fixed single-precision multiplier.
- Configurable exponent/mantissa widths and four run-time rounding modes.
- Handles subnormal inputs and outputs and raises IEEE exception flags.
- Adds a busy output and holds the result stable until the next accept; sits between the operand fetch logic and the matrix-multiply accumulator.

Parameters:
- EXP_W, 8: exponent field width (supported 5..11).
- MAN_W, 23: stored fraction width (supported 10..52). Total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din1  input  W  operand A (sign | exp | fraction).
- din2  input  W  operand B.
- rmode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- din_rdy  input  1  operands valid; sampled only when busy=0.
- busy  output  1  high from the cycle after accept until dout_rdy pulses.
- dout  output  W  result; held until next accept.
- dout_rdy  output  1  one-cycle pulse, result valid.
- flags  output  4  {invalid, overflow, underflow, inexact}; valid with dout, held alongside it.

Behaviour:
- Reset (async, any state, including mid-operation): FSM to IDLE. dout=0, dout_rdy=0, busy=0, flags=0. The operation in progress is discarded.
- Accept rule: din_rdy=1 while in IDLE with busy=0. On accept, din1, din2 and rmode are registered. din_rdy is ignored while busy=1.
- FSM states: IDLE, UNPACK, SPECIAL, MUL, NORM, ROUND, PACK, DONE.
- IDLE -> UNPACK on accept.
- UNPACK:
  - Split fields; bias B = 2^(EXP_W-1)-1.
  - Subnormal input: exponent 1-B, hidden bit 0. Normal input: hidden bit 1.
- SPECIAL:
  - NaN input, or inf*0 -> canonical NaN, invalid=1.
  - Canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0 (0x7FC00000 for the default parameters).
  - inf*finite-nonzero -> signed inf.
  - Zero*finite -> signed zero.
  - Special cases go straight to DONE; otherwise -> MUL.
- MUL:
  - Product of the two (MAN_W+1)-bit significands into a 2*(MAN_W+1)-bit register.
  - Exponent = eA + eB + 1, computed signed, width EXP_W+3 (no wrap).
  - Sign = sA ^ sB.
- NORM (one shift per cycle; loops in NORM):
  - Left shift, exponent-1, while MSB=0 and exponent > 1-B.
  - Right shift, exponent+1, while exponent < 1-B; shifted-out bits OR into sticky.
  - If exponent < 1-B-MAN_W-2, collapse the significand to sticky only.
  - Then -> ROUND.
- ROUND:
  - Keep MAN_W+1 bits, with guard, round and sticky bits.
  - Increment condition by mode:
    - RNE: G & (R|S|LSB).
    - RTZ: never.
    - RUP: (G|R|S) & ~sign.
    - RDN: (G|R|S) & sign.
  - Significand carry-out -> shift right 1, exponent+1.
  - A subnormal that rounds up into the hidden bit becomes the minimum normal.
  - inexact = G|R|S.
- PACK:
  - Exponent > B -> overflow=1, inexact=1. Result by mode:
    - RNE -> inf.
    - RTZ -> max finite.
    - RUP -> +inf if positive, else -max finite.
    - RDN -> -inf if negative, else +max finite.
  - Hidden bit 0 -> biased exponent 0 (subnormal/zero).
  - underflow = tiny (after rounding) & inexact.
- DONE:
  - dout and flags update; dout_rdy=1 for one cycle; busy=0.
  - Next state IDLE. A new accept may occur the cycle after DONE.
- Latency:
  - Normal operands: accept-to-dout_rdy = 7 cycles when no shift is needed.
  - Each NORM shift adds 1 cycle. Bound: 7 + 2*(MAN_W+2).
- Exact zero result from underflow keeps the computed sign.

Test Plan:
- Default params, RNE: 0x3FC00000 * 0x40000000 -> dout=0x40400000, flags=0000, dout_rdy pulse 7 cycles after accept, busy high in between.
- 0x3F800001 * 0x3F800001 -> RNE: 0x3F800002, inexact=1. RUP: 0x3F800003. RTZ: 0x3F800002.
- 0x7F7FFFFF * 0x40000000 -> RNE: 0x7F800000 with overflow=1, inexact=1. RTZ: 0x7F7FFFFF with overflow=1. Sign-flipped operand A, RUP: 0xFF7FFFFF.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1.
- NaN * 1.0 -> 0x7FC00000, invalid=1.
- 0x00800000 * 0x3F000000 -> 0x00400000, underflow=0, inexact=0.
- 0x00000001 * 0x3F000000 RNE -> 0x00000000, underflow=1, inexact=1.
- EXP_W=5, MAN_W=10: 0x3C00 * 0x3C00 -> 0x3C00. 0x7BFF * 0x4000 RNE -> 0x7C00, overflow=1.
- Assert rst during NORM -> outputs zero immediately. din_rdy pulsed while busy -> ignored. Back-to-back operations -> both results correct.
